// File: rtl/decode_buffer_if.sv
// decode_buffer_if: fetch-side and execute-side handshakes of the decode stage.
//   in_valid/in_ready/in_pc/in_instr          fetch -> decode instruction stream
//   out_valid/out_ready/out_*                 decode -> execute pipeline register
//   redirect_valid/redirect_pc                decode -> fetch restart request
// master: the decode stage itself; slave: the surrounding pipeline.
interface decode_buffer_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_srca;
  logic [XLEN-1:0] out_srcb;
  logic [4:0]      out_dst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_imm, out_srca, out_srcb,
           out_dst, redirect_valid, redirect_pc
  );

  modport slave (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_imm, out_srca, out_srcb,
           out_dst, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/decode_buffer.sv
// decode_buffer: circular instruction buffer feeding a decode stage that builds
// the immediate, selects operands (register file or forwarding), resolves
// branches/jumps and loads a registered decode/execute stage.
//   clk, reset (async, active-low)
//   flush              discard buffer and output register
//   stall              hold the buffer head
//   ra1/ra2, rd1/rd2   register file read port
//   fwd_data, sel_a/b  forwarding sources and operand selects
//   bus                fetch/execute/redirect handshakes (decode_buffer_if.master)
module decode_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int NFWD  = 3,
  localparam int SELW = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 stall,
  output logic [4:0]           ra1,
  output logic [4:0]           ra2,
  input  logic [XLEN-1:0]      rd1,
  input  logic [XLEN-1:0]      rd2,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [SELW-1:0]      sel_a,
  input  logic [SELW-1:0]      sel_b,
  decode_buffer_if.master      bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] out_pc_q, out_imm_q, out_srca_q, out_srcb_q;
  logic [31:0]     out_instr_q;
  logic [4:0]      out_dst_q;

  logic [XLEN-1:0] h_pc;
  logic [31:0]     h_instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [XLEN-1:0] srca, srcb, jalr_sum, target;
  logic            taken, in_ready, issue, take_redirect, enq;

  assign h_pc    = pc_mem_q[head_q];
  assign h_instr = instr_mem_q[head_q];
  assign opcode  = h_instr[6:0];
  assign funct3  = h_instr[14:12];
  assign ra1     = h_instr[19:15];
  assign ra2     = h_instr[24:20];

  assign imm_i = {{(XLEN-12){h_instr[31]}}, h_instr[31:20]};
  assign imm_s = {{(XLEN-12){h_instr[31]}}, h_instr[31:25], h_instr[11:7]};
  // B-immediate carries instr[31] as its sign bit (standard B-type layout)
  assign imm_b = {{(XLEN-13){h_instr[31]}}, h_instr[31], h_instr[7], h_instr[30:25],
                  h_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){h_instr[31]}}, h_instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){h_instr[31]}}, h_instr[31], h_instr[19:12], h_instr[20],
                  h_instr[30:21], 1'b0};

  always_comb begin
    imm = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_IMM32: imm = imm_i;
      OP_STORE:                  imm = imm_s;
      OP_BRANCH:                 imm = imm_b;
      OP_LUI:                    imm = imm_u;
      OP_AUIPC:                  imm = imm_u + h_pc;
      OP_JAL, OP_JALR:           imm = h_pc + XLEN'(4);
      default:                   imm = '0;
    endcase
  end

  // select codes above NFWD fall back to the register file value
  always_comb begin
    srca = rd1;
    srcb = rd2;
    for (int k = 1; k <= NFWD; k++) begin
      if (int'(sel_a) == k) srca = fwd_data[(k-1)*XLEN +: XLEN];
      if (int'(sel_b) == k) srcb = fwd_data[(k-1)*XLEN +: XLEN];
    end
  end

  assign jalr_sum = srca + imm_i;

  always_comb begin
    taken  = 1'b0;
    target = h_pc + imm_b;
    case (opcode)
      OP_BRANCH: begin
        case (funct3)
          3'b000:  taken = (srca == srcb);
          3'b001:  taken = (srca != srcb);
          3'b100:  taken = ($signed(srca) <  $signed(srcb));
          3'b101:  taken = ($signed(srca) >= $signed(srcb));
          3'b110:  taken = (srca <  srcb);
          3'b111:  taken = (srca >= srcb);
          default: taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        taken  = 1'b1;
        target = h_pc + imm_j;
      end
      OP_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign in_ready      = (count_q < CNTW'(DEPTH)) && !redir_valid_q;
  assign issue         = !flush && (count_q != '0) && !stall && (!out_valid_q || bus.out_ready);
  assign take_redirect = issue && taken;
  assign enq           = !flush && bus.in_valid && in_ready && !take_redirect;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    out_valid_d   = out_valid_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    if (flush) begin
      head_d      = tail_q;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else if (take_redirect) begin
      // the branch issues; everything younger (incl. this cycle's fetch) is dropped
      head_d        = tail_q;
      count_d       = '0;
      out_valid_d   = 1'b1;
      redir_valid_d = 1'b1;
      redir_pc_d    = target;
    end else begin
      if (issue) head_d = head_q + PTRW'(1);
      if (enq)   tail_d = tail_q + PTRW'(1);
      case ({enq, issue})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: ;
      endcase
      if (issue)              out_valid_d = 1'b1;
      else if (bus.out_ready) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[tail_q]    <= bus.in_pc;
      instr_mem_q[tail_q] <= bus.in_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      out_pc_q      <= '0;
      out_instr_q   <= '0;
      out_imm_q     <= '0;
      out_srca_q    <= '0;
      out_srcb_q    <= '0;
      out_dst_q     <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      if (issue) begin
        out_pc_q    <= h_pc;
        out_instr_q <= h_instr;
        out_imm_q   <= imm;
        out_srca_q  <= srca;
        out_srcb_q  <= srcb;
        out_dst_q   <= h_instr[11:7];
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.out_instr      = out_instr_q;
  assign bus.out_imm        = out_imm_q;
  assign bus.out_srca       = out_srca_q;
  assign bus.out_srcb       = out_srcb_q;
  assign bus.out_dst        = out_dst_q;
  assign bus.redirect_valid = redir_valid_q;
  assign bus.redirect_pc    = redir_pc_q;
endmodule
